// File: rtl/rv_alu_iter.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define RV_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module rv_alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_sel_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            busy_o
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_XOR, OP_OR, OP_AND,
    OP_SLT, OP_ULT, OP_EQL, OP_NEQL, OP_SGT, OP_UGT, OP_LUI, OP_JAL
  } op_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            fill_q, fill_d;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            start_shift;
  logic [XLEN-1:0] sh_step;

  function automatic logic [XLEN-1:0] zext1(input logic bit_v);
    return {{(XLEN-1){1'b0}}, bit_v};
  endfunction

  // Single-cycle result. Without the barrel shifter this is only reached by
  // shifts with shamt==0, whose result is operand A unchanged.
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] sel,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  sa;
    sa = b[SHW-1:0];
    r  = '0;
    unique case (op_e'(sel))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
`ifdef RV_ALU_BARREL_SHIFT_EN
      OP_SLL:  r = a << sa;
      OP_SRL:  r = a >> sa;
      OP_SRA:  r = XLEN'($signed(a) >>> sa);
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLT:  r = zext1($signed(a) < $signed(b));
      OP_ULT:  r = zext1(a < b);
      OP_EQL:  r = zext1(a == b);
      OP_NEQL: r = zext1(a != b);
      OP_SGT:  r = zext1($signed(a) >= $signed(b));
      OP_UGT:  r = zext1(a >= b);
      OP_LUI:  r = b;
      OP_JAL:  r = a + XLEN'(4);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign shamt    = op_b_i[SHW-1:0];
  assign is_shift = (alu_sel_i == OP_SLL) || (alu_sel_i == OP_SRL) || (alu_sel_i == OP_SRA);

`ifdef RV_ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift && (shamt != '0);
`endif

  // One-bit step; fill_q carries the sign of the original operand for SRA.
  assign sh_step = left_q ? {sh_q[XLEN-2:0], 1'b0} : {fill_q, sh_q[XLEN-1:1]};

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    result_d = result_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    fill_d   = fill_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (valid_i && ready_q) begin
          ready_d = 1'b0;
          if (start_shift) begin
            sh_d    = op_a_i;
            cnt_d   = shamt;
            left_d  = (alu_sel_i == OP_SLL);
            fill_d  = (alu_sel_i == OP_SRA) && op_a_i[XLEN-1];
            busy_d  = 1'b1;
            state_d = S_SHIFT;
          end else begin
            result_d = alu_f(alu_sel_i, op_a_i, op_b_i);
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = sh_step;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      fill_q   <= fill_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_rv_alu_iter.sv
// Randomized + directed bench for rv_alu_iter against a transaction-level model.
module tb_rv_alu_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  alu_sel_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  rv_alu_iter #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .alu_sel_i(alu_sel_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return a >> sh;
      4'd4:  return $signed(a) >>> sh;
      4'd5:  return a ^ b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return (a >= b) ? 32'd1 : 32'd0;
      4'd14: return b;
      default: return a + 32'd4;
    endcase
  endfunction

  // Number of busy cycles an accepted op spends before its result appears.
  function automatic int busy_cycles(input logic [3:0] s, input logic [31:0] b);
`ifdef RV_ALU_BARREL_SHIFT_EN
    return 0;
`else
    return (s >= 4'd2 && s <= 4'd4) ? int'(b[4:0]) : 0;
`endif
  endfunction

  // Transaction-level model of the handshake and the expected result.
  logic        m_init = 1'b0;
  logic        m_rdy = 1'b0, m_vld = 1'b0, m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init <= 1'b1; m_rdy <= 1'b0; m_vld <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else if (m_init) begin
      if (m_vld) begin
        if (ready_i) begin m_vld <= 1'b0; m_rdy <= 1'b1; end
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin m_busy <= 1'b0; m_vld <= 1'b1; end
      end else if (!m_rdy) begin
        m_rdy <= 1'b1;
      end else if (valid_i) begin
        m_res <= ref_alu(alu_sel_i, op_a_i, op_b_i);
        m_rdy <= 1'b0;
        if (busy_cycles(alu_sel_i, op_b_i) == 0) m_vld <= 1'b1;
        else begin m_busy <= 1'b1; m_cnt <= busy_cycles(alu_sel_i, op_b_i); end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_ready", {31'b0, ready_o}, {31'b0, m_rdy});
      chk("m_valid", {31'b0, valid_o}, {31'b0, m_vld});
      chk("m_busy", {31'b0, busy_o}, {31'b0, m_busy});
      if (m_vld) begin
        chk("m_result", result_o, m_res);
        chk("m_zero", {31'b0, zero_o}, {31'b0, (m_res == 32'd0)});
      end
    end
  end

  // Issue one op from IDLE, scramble inputs after acceptance, wait for the result.
  task automatic run_op(input string name, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int n, nb;
    @(negedge clk);
    valid_i = 1'b1; alu_sel_i = s; op_a_i = a; op_b_i = b;
    @(negedge clk);
    valid_i = 1'b0; alu_sel_i = 4'($urandom); op_a_i = $urandom; op_b_i = $urandom;
    n = 1; nb = 0;
    while (!valid_o && n < 100) begin
      if (busy_o) nb++;
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_busy"}, nb, exp_lat - 1);
    chk({name, "_res"}, result_o, exp);
    chk({name, "_zero"}, {31'b0, zero_o}, {31'b0, (exp == 32'd0)});
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1; alu_sel_i = 4'd0; op_a_i = $urandom; op_b_i = $urandom;
      @(negedge clk);
      chk({name, "_hold_res"}, result_o, exp);
      chk({name, "_hold_rdy"}, {31'b0, ready_o}, 32'd0);
      chk({name, "_hold_vld"}, {31'b0, valid_o}, 32'd1);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  localparam int SRA_LAT =
`ifdef RV_ALU_BARREL_SHIFT_EN
    1;
`else
    32;
`endif

  initial begin
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, ready_o}, 32'd1);
    valid_i = 1'b0;

    run_op("add",  4'd0,  32'hFFFFFFFF, 32'd1, 32'h0, 1, 0);
    run_op("sub",  4'd1,  32'd5, 32'd7, 32'hFFFFFFFE, 1, 0);
    run_op("slt",  4'd8,  32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
    run_op("ult",  4'd9,  32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
    run_op("sgt",  4'd12, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
    run_op("ugt",  4'd13, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
    run_op("eql",  4'd10, 32'h1234, 32'h1234, 32'd1, 1, 0);
    run_op("neql", 4'd11, 32'h1234, 32'h1234, 32'd0, 1, 0);
    run_op("sra",  4'd4,  32'h80000000, 32'd31, 32'hFFFFFFFF, SRA_LAT, 0);
    run_op("sll0", 4'd2,  32'd1, 32'd0, 32'd1, 1, 0);
    run_op("jal",  4'd15, 32'h100, 32'd0, 32'h104, 1, 5);

    // Abort a long shift with reset; it must vanish without a result.
    @(negedge clk);
    valid_i = 1'b1; alu_sel_i = 4'd2; op_a_i = 32'd1; op_b_i = 32'd20;
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifndef RV_ALU_BARREL_SHIFT_EN
      chk("abort_busy", {31'b0, busy_o}, 32'd1);
      chk("abort_valid", {31'b0, valid_o}, 32'd0);
`endif
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'b0, valid_o}, 32'd0);
    end
    run_op("lui", 4'd14, 32'h55, 32'hABCDE000, 32'hABCDE000, 1, 0);

    // Random traffic with backpressure and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      valid_i   = 1'($urandom_range(0, 1));
      alu_sel_i = 4'($urandom);
      op_a_i    = ($urandom % 6 == 0) ? 32'h80000000 : $urandom;
      op_b_i    = ($urandom % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom % 5 == 0) op_b_i = op_a_i;
      ready_i   = ($urandom % 4 != 0);
      rst_n     = ($urandom % 700 != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_alu_iter.md
Name: rv_alu_iter

Overview:
- Execute-stage ALU, directly downstream of the ALU control unit; consumes its 4-bit alu_sel plus two XLEN operands.
- Valid/ready handshake on both sides; result held in an output register until accepted.
- Shifts run iteratively, one bit per cycle, to save area. All other ops complete in one compute cycle.
- Result feeds writeback; bit 0 of compare results feeds branch resolution.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  upstream op valid
- ready_o  out  1  block can accept an op
- alu_sel_i  in  4  op select from ALU control
- op_a_i  in  XLEN  operand A (rs1 or PC)
- op_b_i  in  XLEN  operand B (rs2 or immediate)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  XLEN  registered result
- zero_o  out  1  result_o == 0
- busy_o  out  1  state is SHIFT

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- alu_sel encoding (all 16 values defined):
  - 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 XOR, 6 OR, 7 AND
  - 8 SLT (signed a<b), 9 ULT (unsigned a<b), 10 EQL (a==b), 11 NEQL (a!=b)
  - 12 SGT (signed a>=b), 13 UGT (unsigned a>=b)
  - 14 LUI (result=b), 15 JAL (result=a+4)
- Compare ops return a 0/1 result, zero-extended to XLEN.
- Arithmetic: modulo 2^XLEN, no overflow flag. Shift amount is b[4:0] (b[$clog2(XLEN)-1:0] in general).
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE; result_o=0; valid_o=0; busy_o=0; shift counter=0.
  - ready_o is 1 in the cycle after reset is released.
  - Reset mid-SHIFT or mid-DONE aborts the op; the op is dropped with no output.
- FSM states:
  - IDLE: ready_o=1, valid_o=0. On valid_i&&ready_o, latch op, a, b.
    - Non-shift op, or shift with shamt=0: compute into result register and go to DONE.
    - Shift with shamt>0: load the shift register with a, counter=shamt, go to SHIFT.
  - SHIFT: ready_o=0, busy_o=1. Each cycle shift the register by 1:
    - SLL: left, zero fill.
    - SRL: right, zero fill.
    - SRA: right, fill with the original a[XLEN-1].
    - Decrement the counter. When the counter reaches 1, the shift completes that cycle; copy to result_o and go to DONE.
  - DONE: valid_o=1; result_o and zero_o stable. ready_o=0. On ready_i go to IDLE.
- Latency: acceptance edge to valid_o high.
  - Non-shift: 1 cycle.
  - Shift: 1+shamt cycles (shamt=31 gives 32).
- Throughput: at most one op per 2 cycles; IDLE must be revisited between ops.
- Backpressure: valid_o/result_o held indefinitely while ready_i=0.
- Inputs are ignored outside IDLE. Operand changes after acceptance have no effect.
- zero_o is combinational from result_o and is meaningful only while valid_o=1.

Optional Feature:
- Macro: RV_ALU_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. SHIFT state is never entered, busy_o is tied 0, and all ops have 1-cycle latency.
- Undefined: iterative shifting as described above.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with valid_i=1 -> valid_o=0, result_o=0, ready_o=0 during reset; ready_o=1 in the first cycle after release.
- ADD a=0xFFFFFFFF, b=1 -> 1 cycle later valid_o=1, result_o=0, zero_o=1. SUB a=5, b=7 -> 0xFFFFFFFE.
- Compares with a=0xFFFFFFFF, b=1:
  - SLT -> 1, ULT -> 0, SGT -> 0, UGT -> 1.
  - EQL a=b=0x1234 -> 1; NEQL -> 0.
- SRA a=0x80000000, b=31 -> busy_o=1 for 31 cycles, valid_o on cycle 32, result 0xFFFFFFFF. SLL a=1, b=0 -> 1-cycle latency, result 1.
- Backpressure: JAL a=0x100 with ready_i=0 for 5 cycles -> result_o=0x104 held stable; ready_o=0 throughout; new valid_i ignored.
- Abort: SLL a=1, b=20; assert rst_ni=0 at cycle 10 -> valid_o never asserts. The next op, LUI b=0xABCDE000, returns 0xABCDE000.
